// File: rtl/div_iter_unit_if.sv
// ============================================================================
//  div_iter_unit_if
//  Start/ready handshake and operand/result bundle for the iterative divider.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface div_iter_unit_if #(
   parameter int WIDTH = 32
);
   logic                 flush;
   logic                 start_i;
   logic                 signed_div_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   logic                 busy_o;
   logic                 ready_o;
   logic [2*WIDTH-1:0]   result_o;
   logic                 div_zero_o;

   // Requester side (EX stage)
   modport master (
      output flush, start_i, signed_div_i, opdata1_i, opdata2_i,
      input  busy_o, ready_o, result_o, div_zero_o
   );

   // Divider side
   modport slave (
      input  flush, start_i, signed_div_i, opdata1_i, opdata2_i,
      output busy_o, ready_o, result_o, div_zero_o
   );
endinterface

`default_nettype wire

// File: rtl/div_iter_unit.sv
// ============================================================================
//  div_iter_unit
//  Iterative restoring signed/unsigned divider, RADIX_BITS quotient bits per
//  cycle, result = {remainder, quotient}.
//  Optional macro DIV_ZERO_FAST_EN: a divide-by-zero start from IDLE skips
//  the iterations and goes straight to DONE.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module div_iter_unit #(
   parameter int WIDTH      = 32,
   parameter int RADIX_BITS = 1
) (
   input  logic          clk,
   input  logic          rst,
   div_iter_unit_if.slave bus
);

   localparam int N  = WIDTH / RADIX_BITS;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(N);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

`ifdef DIV_ZERO_FAST_EN
   localparam logic FAST_ZERO = 1'b1;
`else
   localparam logic FAST_ZERO = 1'b0;
`endif

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [CW-1:0]      count;
   logic [2*WIDTH:0]   part;          // {remainder, quotient/dividend} shift register
   logic [2*WIDTH:0]   part_nxt;
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH-1:0]   dividend_raw;
   logic               q_neg;
   logic               r_neg;
   logic               zero;
   logic               ready;
   logic               div_zero;
   logic [2*WIDTH-1:0] result;

   logic               do_load;
   logic               do_step;
   logic               do_finish;
   logic               busy;
   logic               start_zero;
   logic [WIDTH-1:0]   abs1;
   logic [WIDTH-1:0]   abs2;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;

   assign start_zero = (bus.opdata2_i == '0);
   assign abs1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
   assign abs2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
   assign q_mag = part[WIDTH-1:0];
   assign r_mag = part[2*WIDTH-1:WIDTH];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; flush overrides everything and drops a coincident start.
   // A start taken in DONE always runs the full iteration count so that two
   // ready pulses can never land on adjacent cycles.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.start_i) state_nxt = (FAST_ZERO && start_zero) ? S_DONE : S_BUSY;
         S_BUSY: if (count == CNT_ONE) state_nxt = S_DONE;
         S_DONE: state_nxt = bus.start_i ? S_BUSY : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (bus.flush) state_nxt = S_IDLE;
   end

   // Output/control decode from the current state
   always_comb begin
      busy      = (state == S_BUSY);
      do_load   = !bus.flush && bus.start_i && ((state == S_IDLE) || (state == S_DONE));
      do_step   = !bus.flush && (state == S_BUSY);
      do_finish = !bus.flush && (state == S_DONE);
   end

   // RADIX_BITS restoring shift-subtract steps on the partial remainder
   always_comb begin
      part_nxt = part;
      for (int i = 0; i < RADIX_BITS; i++) begin
         part_nxt = {part_nxt[2*WIDTH-1:0], 1'b0};
         if (part_nxt[2*WIDTH:WIDTH] >= {1'b0, divisor}) begin
            part_nxt[2*WIDTH:WIDTH] = part_nxt[2*WIDTH:WIDTH] - {1'b0, divisor};
            part_nxt[0]             = 1'b1;
         end
      end
   end

   // Operand capture and iteration datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         part         <= '0;
         divisor      <= '0;
         dividend_raw <= '0;
         q_neg        <= 1'b0;
         r_neg        <= 1'b0;
         zero         <= 1'b0;
         count        <= '0;
      end else if (do_load) begin
         part         <= {{(WIDTH+1){1'b0}}, abs1};
         divisor      <= abs2;
         dividend_raw <= bus.opdata1_i;
         q_neg        <= bus.signed_div_i && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
         r_neg        <= bus.signed_div_i && bus.opdata1_i[WIDTH-1];
         zero         <= start_zero;
         count        <= CNT_LOAD;
      end else if (do_step) begin
         part         <= part_nxt;
         count        <= count - CNT_ONE;
      end
   end

   // Sign fix-up and result/flag registers, written only on a completing DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready    <= 1'b0;
         result   <= '0;
         div_zero <= 1'b0;
      end else begin
         ready <= do_finish;
         if (do_finish) begin
            div_zero <= zero;
            if (zero) result <= {dividend_raw, {WIDTH{1'b1}}};
            else      result <= {(r_neg ? -r_mag : r_mag), (q_neg ? -q_mag : q_mag)};
         end
      end
   end

   assign bus.busy_o     = busy;
   assign bus.ready_o    = ready;
   assign bus.result_o   = result;
   assign bus.div_zero_o = div_zero;

endmodule

`default_nettype wire

// File: tb/tb_div_iter_unit.sv
// ============================================================================
//  tb_div_iter_unit
//  Directed self-checking bench: WIDTH=32/RADIX_BITS=1 and WIDTH=16/RADIX_BITS=2.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_iter_unit;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

`ifdef DIV_ZERO_FAST_EN
   localparam int ZLAT  = 1;
   localparam int ZBUSY = 0;
`else
   localparam int ZLAT  = 33;
   localparam int ZBUSY = 32;
`endif

   div_iter_unit_if #(.WIDTH(32)) bus32 ();
   div_iter_unit_if #(.WIDTH(16)) bus16 ();

   div_iter_unit #(.WIDTH(32), .RADIX_BITS(1)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
   div_iter_unit #(.WIDTH(16), .RADIX_BITS(2)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one 32-bit divide at the current cycle; returns the edge count to
   // ready_o (-1 if it never came) and the number of cycles busy_o was high.
   task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
      bus32.start_i = 1'b1; bus32.signed_div_i = sgn;
      bus32.opdata1_i = a;  bus32.opdata2_i = b;
      @(posedge clk); #1;
      bus32.start_i = 1'b0;
      lat = -1; bcnt = 0;
      for (int k = 1; k <= 40; k++) begin
         if (bus32.busy_o) bcnt++;
         @(posedge clk); #1;
         if (bus32.ready_o) begin lat = k; break; end
      end
   endtask

   task automatic run16(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
      bus16.start_i = 1'b1; bus16.signed_div_i = sgn;
      bus16.opdata1_i = a;  bus16.opdata2_i = b;
      @(posedge clk); #1;
      bus16.start_i = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (bus16.ready_o) begin lat = k; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus32.busy_o, bus32.ready_o, bus32.div_zero_o, bus32.result_o} !== 67'd0) begin
         n_bad++; $display("FAIL reset32: got %h want 0", {bus32.busy_o, bus32.ready_o, bus32.div_zero_o, bus32.result_o});
      end
      n_cmp++;
      if ({bus16.busy_o, bus16.ready_o, bus16.div_zero_o, bus16.result_o} !== 35'd0) begin
         n_bad++; $display("FAIL reset16: got %h want 0", {bus16.busy_o, bus16.ready_o, bus16.div_zero_o, bus16.result_o});
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned;
      logic [31:0] ta [3];
      logic [31:0] tb [3];
      logic [63:0] te [3];
      int lat, bcnt;
      ta[0] = 32'd100;        tb[0] = 32'd7;  te[0] = {32'd2, 32'd14};
      ta[1] = 32'hFFFF_FFFF;  tb[1] = 32'd16; te[1] = {32'hF, 32'h0FFF_FFFF};
      ta[2] = 32'd0;          tb[2] = 32'd5;  te[2] = 64'd0;
      for (int i = 0; i < 3; i++) begin
         run32(1'b0, ta[i], tb[i], lat, bcnt);
         n_cmp++;
         if (lat !== 33) begin n_bad++; $display("FAIL unsigned[%0d] latency: got %0d want 33", i, lat); end
         n_cmp++;
         if (bcnt !== 32) begin n_bad++; $display("FAIL unsigned[%0d] busy cycles: got %0d want 32", i, bcnt); end
         n_cmp++;
         if (bus32.result_o !== te[i]) begin n_bad++; $display("FAIL unsigned[%0d] result: got %h want %h", i, bus32.result_o, te[i]); end
         n_cmp++;
         if (bus32.div_zero_o !== 1'b0) begin n_bad++; $display("FAIL unsigned[%0d] div_zero: got %b want 0", i, bus32.div_zero_o); end
         @(posedge clk); #1;
         n_cmp++;
         if (bus32.ready_o !== 1'b0) begin n_bad++; $display("FAIL unsigned[%0d] ready width: got %b want 0", i, bus32.ready_o); end
      end
   endtask

   task automatic test_signed;
      logic [31:0] ta [3];
      logic [31:0] tb [3];
      logic [63:0] te [3];
      int lat, bcnt;
      ta[0] = 32'hFFFF_FFF9; tb[0] = 32'd2;          te[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
      ta[1] = 32'd7;         tb[1] = 32'hFFFF_FFFE;  te[1] = {32'd1, 32'hFFFF_FFFD};
      ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF;  te[2] = {32'd0, 32'h8000_0000};
      for (int i = 0; i < 3; i++) begin
         run32(1'b1, ta[i], tb[i], lat, bcnt);
         n_cmp++;
         if (lat !== 33) begin n_bad++; $display("FAIL signed[%0d] latency: got %0d want 33", i, lat); end
         n_cmp++;
         if (bus32.result_o !== te[i]) begin n_bad++; $display("FAIL signed[%0d] result: got %h want %h", i, bus32.result_o, te[i]); end
         n_cmp++;
         if (bus32.div_zero_o !== 1'b0) begin n_bad++; $display("FAIL signed[%0d] div_zero: got %b want 0", i, bus32.div_zero_o); end
      end
   endtask

   task automatic test_div_zero;
      int lat, bcnt;
      run32(1'b0, 32'h1234, 32'd0, lat, bcnt);
      n_cmp++;
      if (lat !== ZLAT) begin n_bad++; $display("FAIL divzero latency: got %0d want %0d", lat, ZLAT); end
      n_cmp++;
      if (bcnt !== ZBUSY) begin n_bad++; $display("FAIL divzero busy cycles: got %0d want %0d", bcnt, ZBUSY); end
      n_cmp++;
      if (bus32.result_o !== {32'h1234, 32'hFFFF_FFFF}) begin
         n_bad++; $display("FAIL divzero result: got %h want %h", bus32.result_o, {32'h1234, 32'hFFFF_FFFF});
      end
      n_cmp++;
      if (bus32.div_zero_o !== 1'b1) begin n_bad++; $display("FAIL divzero flag: got %b want 1", bus32.div_zero_o); end
      @(posedge clk); #1;
      n_cmp++;
      if (bus32.ready_o !== 1'b0) begin n_bad++; $display("FAIL divzero ready width: got %b want 0", bus32.ready_o); end
      // Signed dividend with zero divisor: remainder is the raw dividend
      run32(1'b1, 32'hFFFF_FFFB, 32'd0, lat, bcnt);
      n_cmp++;
      if (bus32.result_o !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin
         n_bad++; $display("FAIL divzero signed result: got %h want %h", bus32.result_o, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
      end
   endtask

   // Relies on the result/flag left by test_div_zero
   task automatic test_flush;
      int lat, bcnt;
      bus32.start_i = 1'b1; bus32.signed_div_i = 1'b0;
      bus32.opdata1_i = 32'd1000; bus32.opdata2_i = 32'd3;
      @(posedge clk); #1;
      bus32.start_i = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      bus32.flush = 1'b1;
      @(posedge clk); #1;
      bus32.flush = 1'b0;
      n_cmp++;
      if (bus32.busy_o !== 1'b0) begin n_bad++; $display("FAIL flush busy: got %b want 0", bus32.busy_o); end
      n_cmp++;
      if (bus32.ready_o !== 1'b0) begin n_bad++; $display("FAIL flush ready: got %b want 0", bus32.ready_o); end
      n_cmp++;
      if (bus32.result_o !== {32'hFFFF_FFFB, 32'hFFFF_FFFF} || bus32.div_zero_o !== 1'b1) begin
         n_bad++; $display("FAIL flush held result: got %h/%b want %h/1", bus32.result_o, bus32.div_zero_o, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
      end
      run32(1'b0, 32'd9, 32'd3, lat, bcnt);
      n_cmp++;
      if (lat !== 33 || bus32.result_o !== {32'd0, 32'd3}) begin
         n_bad++; $display("FAIL flush restart: got lat %0d result %h want lat 33 result %h", lat, bus32.result_o, {32'd0, 32'd3});
      end
      n_cmp++;
      if (bus32.div_zero_o !== 1'b0) begin n_bad++; $display("FAIL flush restart div_zero: got %b want 0", bus32.div_zero_o); end
      // start coinciding with flush is dropped
      bus32.start_i = 1'b1; bus32.flush = 1'b1;
      @(posedge clk); #1;
      bus32.start_i = 1'b0; bus32.flush = 1'b0;
      n_cmp++;
      if (bus32.busy_o !== 1'b0) begin n_bad++; $display("FAIL flush drops start: busy got %b want 0", bus32.busy_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int lat;
      bus32.start_i = 1'b1; bus32.signed_div_i = 1'b0;
      bus32.opdata1_i = 32'd100; bus32.opdata2_i = 32'd7;
      @(posedge clk); #1;
      bus32.start_i = 1'b0;
      repeat (32) begin @(posedge clk); #1; end
      // DONE cycle of the first divide
      bus32.start_i = 1'b1; bus32.opdata1_i = 32'd50; bus32.opdata2_i = 32'd5;
      @(posedge clk); #1;
      bus32.start_i = 1'b0;
      n_cmp++;
      if (bus32.ready_o !== 1'b1 || bus32.result_o !== {32'd2, 32'd14}) begin
         n_bad++; $display("FAIL b2b first: got ready %b result %h want 1 %h", bus32.ready_o, bus32.result_o, {32'd2, 32'd14});
      end
      n_cmp++;
      if (bus32.busy_o !== 1'b1) begin n_bad++; $display("FAIL b2b no gap: busy got %b want 1", bus32.busy_o); end
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus32.ready_o) begin lat = k; break; end
      end
      n_cmp++;
      if (lat !== 33) begin n_bad++; $display("FAIL b2b second latency: got %0d want 33", lat); end
      n_cmp++;
      if (bus32.result_o !== {32'd0, 32'd10}) begin
         n_bad++; $display("FAIL b2b second result: got %h want %h", bus32.result_o, {32'd0, 32'd10});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_radix2;
      int lat;
      run16(1'b0, 16'hFFFF, 16'h0003, lat);
      n_cmp++;
      if (lat !== 9) begin n_bad++; $display("FAIL r2 latency: got %0d want 9", lat); end
      n_cmp++;
      if (bus16.result_o !== {16'h0000, 16'h5555}) begin
         n_bad++; $display("FAIL r2 unsigned result: got %h want %h", bus16.result_o, {16'h0000, 16'h5555});
      end
      run16(1'b1, 16'hFF9C, 16'd7, lat);
      n_cmp++;
      if (lat !== 9 || bus16.result_o !== {16'hFFFE, 16'hFFF2}) begin
         n_bad++; $display("FAIL r2 signed: got lat %0d result %h want lat 9 result %h", lat, bus16.result_o, {16'hFFFE, 16'hFFF2});
      end
      // asynchronous reset in the middle of an operation
      bus16.start_i = 1'b1; bus16.signed_div_i = 1'b0;
      bus16.opdata1_i = 16'd1000; bus16.opdata2_i = 16'd7;
      @(posedge clk); #1;
      bus16.start_i = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus16.busy_o, bus16.ready_o, bus16.div_zero_o, bus16.result_o} !== 35'd0) begin
         n_bad++; $display("FAIL r2 async reset16: got %h want 0", {bus16.busy_o, bus16.ready_o, bus16.div_zero_o, bus16.result_o});
      end
      n_cmp++;
      if ({bus32.busy_o, bus32.ready_o, bus32.div_zero_o, bus32.result_o} !== 67'd0) begin
         n_bad++; $display("FAIL r2 async reset32: got %h want 0", {bus32.busy_o, bus32.ready_o, bus32.div_zero_o, bus32.result_o});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1;
      bus32.flush = 1'b0; bus32.start_i = 1'b0; bus32.signed_div_i = 1'b0;
      bus32.opdata1_i = '0; bus32.opdata2_i = '0;
      bus16.flush = 1'b0; bus16.start_i = 1'b0; bus16.signed_div_i = 1'b0;
      bus16.opdata1_i = '0; bus16.opdata2_i = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_flush();
      test_back_to_back();
      test_radix2();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
